// File: rtl/fir_serial_mac.sv
// Time-multiplexed N-tap direct-form FIR: one multiplier and one accumulator walk all taps,
// with a runtime coefficient bank, valid/ready handshakes, round-half-up and saturation.
module fir_serial_mac #(
  parameter int WIDTH     = 16,
  parameter int NTAPS     = 8,
  parameter int OUT_SHIFT = WIDTH - 1,
  localparam int AW       = $clog2(NTAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    coeff_we,
  input  logic [AW-1:0]           coeff_addr,
  input  logic signed [WIDTH-1:0] coeff_wdata,
  output logic                    coeff_drop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data
);

  localparam int ACC_W = 2 * WIDTH + $clog2(NTAPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << (OUT_SHIFT - 1)) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic [1:0]                state;
  logic signed [WIDTH-1:0]   x [NTAPS];
  logic signed [WIDTH-1:0]   c [NTAPS];
  logic signed [ACC_W-1:0]   acc;
  logic [AW-1:0]             k;

  logic                      accept;
  logic                      last_tap;
  logic                      coeff_hit;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W:0]     rounded;
  logic signed [ACC_W:0]     shifted;
  logic signed [WIDTH-1:0]   sat;

  always_comb begin
    in_ready  = (state == S_IDLE) && !rst;
    accept    = in_valid && in_ready;
    last_tap  = (k == AW'(NTAPS - 1));
    coeff_hit = coeff_we && (int'(coeff_addr) < NTAPS);
    prod      = (2 * WIDTH)'(x[k]) * (2 * WIDTH)'(c[k]);
    acc_sum   = acc + {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
    // Rounding is done one bit wider so the half-LSB add can never wrap the sum.
    rounded   = {acc_sum[ACC_W-1], acc_sum} + RND;
    shifted   = rounded >>> OUT_SHIFT;
    sat       = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      k          <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      coeff_drop <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        x[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      // The bank is read every MAC cycle, so writes there are refused and flagged.
      coeff_drop <= coeff_we && (state == S_MAC);
      if (coeff_hit && (state != S_MAC)) begin
        c[coeff_addr] <= coeff_wdata;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int unsigned i = 1; i < NTAPS; i++) begin
              x[i] <= x[i-1];
            end
            x[0]  <= in_data;
            acc   <= '0;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          k   <= k + 1'b1;
          if (last_tap) begin
            k         <= '0;
            out_data  <= sat;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: a reference filter model queues the expected output
// at each accept edge; scenario tasks pop and compare when the DUT presents a result.
module tb_fir_serial_mac;

  localparam int WIDTH = 16;
  localparam int NTAPS = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              coeff_we;
  logic [2:0]        coeff_addr;
  logic [WIDTH-1:0]  coeff_wdata;
  logic              coeff_drop;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int m_x [NTAPS];
  int m_c [NTAPS];
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  fir_serial_mac #(.WIDTH(16), .NTAPS(8), .OUT_SHIFT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .coeff_drop(coeff_drop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [WIDTH-1:0] model_out();
    longint acc = 0;
    longint r;
    for (int i = 0; i < NTAPS; i++) acc += longint'(m_x[i]) * longint'(m_c[i]);
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      m_x[i] = 0;
      m_c[i] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic logic [WIDTH-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic we, input int addr,
                      input logic [WIDTH-1:0] wd);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    coeff_we = we; coeff_addr = 3'(addr); coeff_wdata = wd;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    if (we) m_c[addr] = int'($signed(wd));
    for (int i = NTAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = int'($signed(d));
    exp_q.push_back(model_out());
    @(negedge clk);
    in_valid = 1'b0; coeff_we = 1'b0;
  endtask

  task automatic write_coeff(input int addr, input logic [WIDTH-1:0] wd, input bit honoured);
    coeff_we = 1'b1; coeff_addr = 3'(addr); coeff_wdata = wd;
    @(posedge clk);
    if (honoured) m_c[addr] = int'($signed(wd));
    @(negedge clk);
    coeff_we = 1'b0;
  endtask

  // Feeds one sample with out_ready=1; reports output, its cycle and in_ready-low cycles.
  task automatic run_sample(input logic [WIDTH-1:0] d, input logic we, input int addr,
                            input logic [WIDTH-1:0] wd, output logic [WIDTH-1:0] got,
                            output int lat, output int low);
    send(d, we, addr, wd);
    lat = -1; low = -1; got = 'x;
    for (int n = 1; n <= 40; n++) begin
      if (out_valid && lat < 0) begin
        lat = n;
        got = out_data;
      end
      if (in_ready) begin
        low = n - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; coeff_we = 1'b0; coeff_addr = '0;
    coeff_wdata = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'd0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (coeff_drop !== 1'b0) begin n_bad++; $display("FAIL reset_coeff_drop: got %b want 0", coeff_drop); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_impulse();
    logic [WIDTH-1:0] got, e;
    int lat, low;
    for (int i = 0; i < NTAPS; i++) write_coeff(i, 16'h4000, 1'b1);
    for (int s = 0; s <= NTAPS; s++) begin
      run_sample((s == 0) ? 16'd1000 : 16'd0, 1'b0, 0, '0, got, lat, low);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL impulse_data[%0d]: got %0d want %0d", s, $signed(got), $signed(e)); end
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL impulse_latency[%0d]: got %0d want 9", s, lat); end
      n_cmp++; if (low !== 9) begin n_bad++; $display("FAIL impulse_ready_low[%0d]: got %0d want 9", s, low); end
    end
  endtask

  task automatic test_saturation();
    logic [WIDTH-1:0] got, e;
    int lat, low;
    for (int i = 0; i < NTAPS; i++) write_coeff(i, 16'h7FFF, 1'b1);
    for (int s = 0; s < 2 * NTAPS; s++) begin
      run_sample((s < NTAPS) ? 16'h7FFF : 16'h8000, 1'b0, 0, '0, got, lat, low);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL saturation[%0d]: got %0d want %0d", s, $signed(got), $signed(e)); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held, e, got;
    int n = 0, lat, low;
    out_ready = 1'b0;
    send(16'd1234, 1'b0, 0, '0);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    held = out_data;
    e = pop_exp();
    n_cmp++; if (held !== e || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_data: got %0d valid %b want %0d valid 1", $signed(held), out_valid, $signed(e)); end
    in_valid = 1'b1; in_data = 16'd77;
    coeff_we = 1'b1; coeff_addr = 3'd1; coeff_wdata = 16'h1000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      if (i == 0) m_c[1] = 4096;
      @(negedge clk);
      coeff_we = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== held) begin n_bad++; $display("FAIL bp_hold[%0d]: got valid %b data %0d want valid 1 data %0d", i, out_valid, $signed(out_data), $signed(held)); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (coeff_drop !== 1'b0) begin n_bad++; $display("FAIL bp_coeff_drop[%0d]: got %b want 0", i, coeff_drop); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got valid %b ready %b want 0 1", out_valid, in_ready); end
    n_cmp++; if (out_data !== held) begin n_bad++; $display("FAIL bp_data_kept: got %0d want %0d", $signed(out_data), $signed(held)); end
    run_sample(16'd0, 1'b0, 0, '0, got, lat, low);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL bp_next_sample: got %0d want %0d", $signed(got), $signed(e)); end
  endtask

  task automatic test_coeff_during_mac();
    logic [WIDTH-1:0] got, e;
    int lat, low;
    for (int i = 0; i < NTAPS; i++) write_coeff(i, 16'h4000, 1'b1);
    send(16'd1000, 1'b0, 0, '0);
    coeff_we = 1'b1; coeff_addr = 3'd0; coeff_wdata = 16'h0000;
    @(negedge clk);
    coeff_we = 1'b0;
    n_cmp++; if (coeff_drop !== 1'b1) begin n_bad++; $display("FAIL mac_drop_pulse: got %b want 1", coeff_drop); end
    @(negedge clk);
    n_cmp++; if (coeff_drop !== 1'b0) begin n_bad++; $display("FAIL mac_drop_single: got %b want 0", coeff_drop); end
    got = 'x;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) got = out_data;
      if (in_ready) break;
      @(negedge clk);
    end
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL mac_old_coeff: got %0d want %0d", $signed(got), $signed(e)); end
    write_coeff(0, 16'h0000, 1'b1);
    n_cmp++; if (coeff_drop !== 1'b0) begin n_bad++; $display("FAIL idle_no_drop: got %b want 0", coeff_drop); end
    run_sample(16'd1000, 1'b0, 0, '0, got, lat, low);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL idle_coeff_zero: got %0d want %0d", $signed(got), $signed(e)); end
    run_sample(16'd500, 1'b1, 0, 16'h2000, got, lat, low);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL same_edge_coeff: got %0d want %0d", $signed(got), $signed(e)); end
  endtask

  task automatic test_reset_mid_mac();
    logic [WIDTH-1:0] got, e;
    int lat, low, seen = 0;
    send(16'd3000, 1'b0, 0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_mac_valid: got %0d valid cycles want 0", seen); end
    run_sample(16'd0, 1'b0, 0, '0, got, lat, low);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rst_coeffs_cleared: got %0d want %0d", $signed(got), $signed(e)); end
    for (int i = 0; i < NTAPS; i++) write_coeff(i, 16'h4000, 1'b1);
    run_sample(16'd0, 1'b0, 0, '0, got, lat, low);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rst_delay_cleared: got %0d want %0d", $signed(got), $signed(e)); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_coeff_during_mac();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
